// File: rtl/iaq_chan_sched.sv
`default_nettype none
// ============================================================================
//  Module      : iaq_chan_sched
//  Description : Four-channel round-robin scheduler in front of one shared
//                inverse adaptive quantizer (IAQ). Grants one requesting
//                channel at a time, hands its I/y operands to the datapath,
//                waits for completion and returns the DQ result tagged with
//                the channel index.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WDOG_LIM   : WAIT cycles before a watchdog abort (1..255)
//  Optional feature
//    IAQ_SCHED_WDOG_EN : when defined, an 8-bit watchdog aborts a WAIT that
//                        lasts WDOG_LIM cycles (res_err=1, res_dq=0). When
//                        undefined, WAIT persists until dq_done.
//  Ports
//    clk        in   1   system clock, rising edge
//    reset      in   1   asynchronous reset, active low
//    scan_in0   in   1   DFT scan in (unused before insertion)
//    scan_en    in   1   DFT scan enable (unused before insertion)
//    scan_out0  out  1   DFT scan out, 0 before insertion
//    req        in   4   per-channel request level
//    ch_i       in   16  per-channel 4-bit code I, channel n at [4n+3:4n]
//    ch_y       in   52  per-channel 13-bit scale y, channel n at [13n+12:13n]
//    gnt        out  4   one-hot grant pulse
//    dq_start   out  1   datapath start pulse
//    dq_i/dq_y  out  4/13 operands of the granted channel
//    dq_done    in   1   datapath completion pulse
//    dq_res     in   15  datapath DQ result
//    res_valid  out  1   result strobe
//    res_ch     out  2   channel index of the result
//    res_dq     out  15  DQ result
//    res_err    out  1   watchdog abort flag
// ============================================================================
module iaq_chan_sched #(
    parameter int WDOG_LIM = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_en,
    output logic        scan_out0,
    input  logic [3:0]  req,
    input  logic [15:0] ch_i,
    input  logic [51:0] ch_y,
    output logic [3:0]  gnt,
    output logic        dq_start,
    output logic [3:0]  dq_i,
    output logic [12:0] dq_y,
    input  logic        dq_done,
    input  logic [14:0] dq_res,
    output logic        res_valid,
    output logic [1:0]  res_ch,
    output logic [14:0] res_dq,
    output logic        res_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [3:0]  r_gnt,       w_gnt_nxt;
    logic        r_dq_start,  w_dq_start_nxt;
    logic [3:0]  r_dq_i,      w_dq_i_nxt;
    logic [12:0] r_dq_y,      w_dq_y_nxt;
    logic [1:0]  r_idx,       w_idx_nxt;
    logic [1:0]  r_rr_ptr,    w_rr_ptr_nxt;
    logic        r_res_valid, w_res_valid_nxt;
    logic [1:0]  r_res_ch,    w_res_ch_nxt;
    logic [14:0] r_res_dq,    w_res_dq_nxt;
    logic        r_res_err,   w_res_err_nxt;

`ifdef IAQ_SCHED_WDOG_EN
    localparam logic [7:0] c_WDOG_LAST = 8'(WDOG_LIM - 1);
    logic [7:0]  r_wdog,      w_wdog_nxt;
`endif

    logic        w_any;
    logic [1:0]  w_sel;
    logic        w_unused;

    // Scan hooks are stitched in at DFT insertion; functionally inert here.
    assign w_unused  = ^{scan_in0, scan_en, 8'(WDOG_LIM)};
    assign scan_out0 = 1'b0;

    // Round-robin pick: walk from the highest offset down so the candidate
    // closest to r_rr_ptr is the one left standing.
    always_comb begin
        w_any = |req;
        w_sel = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_rr_ptr + 2'(k)]) begin
                w_sel = r_rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = 4'b0000;
        w_dq_start_nxt  = 1'b0;
        w_dq_i_nxt      = r_dq_i;
        w_dq_y_nxt      = r_dq_y;
        w_idx_nxt       = r_idx;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_res_valid_nxt = 1'b0;
        w_res_ch_nxt    = r_res_ch;
        w_res_dq_nxt    = r_res_dq;
        w_res_err_nxt   = r_res_err;
`ifdef IAQ_SCHED_WDOG_EN
        w_wdog_nxt      = r_wdog;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = 4'b0001 << w_sel;
                    w_dq_i_nxt  = ch_i[{w_sel, 2'b00} +: 4];
                    w_dq_y_nxt  = ch_y[6'(w_sel) * 6'd13 +: 13];
                    w_idx_nxt   = w_sel;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_dq_start_nxt = 1'b1;
`ifdef IAQ_SCHED_WDOG_EN
                w_wdog_nxt     = 8'd0;
`endif
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                // r_dq_start is high only in the first WAIT cycle; a done
                // pulse there cannot belong to this operation.
                if (dq_done && !r_dq_start) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_ch_nxt    = r_idx;
                    w_res_dq_nxt    = dq_res;
                    w_res_err_nxt   = 1'b0;
                    w_state_nxt     = S_DONE;
                end
`ifdef IAQ_SCHED_WDOG_EN
                else if (r_wdog == c_WDOG_LAST) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_ch_nxt    = r_idx;
                    w_res_dq_nxt    = 15'd0;
                    w_res_err_nxt   = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_wdog_nxt      = r_wdog + 8'd1;
                end
`endif
            end
            S_DONE: begin
                w_rr_ptr_nxt = r_idx + 2'd1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= 4'b0000;
            r_dq_start  <= 1'b0;
            r_dq_i      <= 4'd0;
            r_dq_y      <= 13'd0;
            r_idx       <= 2'd0;
            r_rr_ptr    <= 2'd0;
            r_res_valid <= 1'b0;
            r_res_ch    <= 2'd0;
            r_res_dq    <= 15'd0;
            r_res_err   <= 1'b0;
`ifdef IAQ_SCHED_WDOG_EN
            r_wdog      <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_dq_start  <= w_dq_start_nxt;
            r_dq_i      <= w_dq_i_nxt;
            r_dq_y      <= w_dq_y_nxt;
            r_idx       <= w_idx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_ch    <= w_res_ch_nxt;
            r_res_dq    <= w_res_dq_nxt;
            r_res_err   <= w_res_err_nxt;
`ifdef IAQ_SCHED_WDOG_EN
            r_wdog      <= w_wdog_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign dq_start  = r_dq_start;
    assign dq_i      = r_dq_i;
    assign dq_y      = r_dq_y;
    assign res_valid = r_res_valid;
    assign res_ch    = r_res_ch;
    assign res_dq    = r_res_dq;
    assign res_err   = r_res_err;

endmodule
`default_nettype wire

// File: doc/iaq_chan_sched.md
IAQ_CHAN_SCHED -- requirements
Module: iaq_chan_sched

Interface
REQ-001 Parameter WDOG_LIM, 63, number of WAIT cycles before watchdog abort; range 1..255.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 scan_in0, scan_en  input  1 each  DFT scan hooks; functionally ignored pre-insertion.
REQ-005 scan_out0  output  1  DFT scan out; driven 0 pre-insertion.
REQ-006 req  input  4  per-channel request for one inverse-quantizer operation; level, held until granted.
REQ-007 ch_i  input  16  4-bit ADPCM code I per channel; channel n at bits [4n+3:4n].
REQ-008 ch_y  input  52  13-bit quantizer scale factor y per channel; channel n at bits [13n+12:13n].
REQ-009 gnt  output  4  one-hot, one-cycle grant pulse to the selected channel.
REQ-010 dq_start  output  1  one-cycle start pulse to the shared inverse adaptive quantizer.
REQ-011 dq_i, dq_y  output  4, 13  operands latched from the granted channel.
REQ-012 dq_done, dq_res  input  1, 15  datapath completion pulse and DQ result (sign-magnitude).
REQ-013 res_valid  output  1  one-cycle result strobe.
REQ-014 res_ch, res_dq, res_err  output  2, 15, 1  channel index, DQ value, watchdog-abort flag.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, DONE; encoding free.
REQ-016 IDLE: when any req bit is 1, select channel by round-robin starting at rr_ptr, pulse gnt for that channel, latch its I and y into dq_i/dq_y, latch index, go to ISSUE; else stay.
REQ-017 ISSUE: assert dq_start for exactly one cycle, go to WAIT.
REQ-018 WAIT: on dq_done=1 latch dq_res, go to DONE; dq_done outside WAIT is ignored.
REQ-019 DONE: assert res_valid one cycle with res_ch = latched index, res_dq = latched result, res_err = 0; set rr_ptr = index+1 mod 4; go to IDLE.
REQ-020 Round-robin: search order rr_ptr, rr_ptr+1, ... wrapping 3->0; rr_ptr starts at 0.
REQ-021 Minimum turnaround: req seen in IDLE at cycle t -> gnt at t+1, dq_start at t+2; dq_done at cycle d -> res_valid at d+1.
REQ-022 At most one operation outstanding; gnt never asserted outside IDLE->ISSUE transition.
REQ-023 Requests arriving during ISSUE/WAIT/DONE are held by requester and arbitrated in next IDLE.
REQ-024 dq_done coincident with dq_start cycle is ignored (datapath latency >= 1).
REQ-025 res_dq, res_ch, dq_i, dq_y hold their last value between strobes.

Reset
REQ-026 reset=0 forces IDLE immediately, regardless of clk, including mid-WAIT; in-flight result discarded.
REQ-027 Reset values: gnt=0, dq_start=0, dq_i=0, dq_y=0, res_valid=0, res_ch=0, res_dq=0, res_err=0, rr_ptr=0, watchdog count=0, scan_out0=0.
REQ-028 First arbitration possible on the first rising edge after reset returns to 1.

Configuration
REQ-029 Macro IAQ_SCHED_WDOG_EN defined: 8-bit counter clears on WAIT entry, increments each WAIT cycle; when it reaches WDOG_LIM without dq_done, go to DONE with res_dq=0, res_err=1; dq_done on the expiry cycle wins (normal result, res_err=0).
REQ-030 Macro IAQ_SCHED_WDOG_EN undefined: no counter; WAIT persists until dq_done; res_err tied 0.

Verification
REQ-031 Single request: req=4'b0100, ch_i[11:8]=4'hA, ch_y[38:26]=13'h0555, dq_done 3 cycles after dq_start with dq_res=15'h1234 -> gnt=4'b0100 one cycle, dq_i=4'hA, dq_y=13'h0555, res_valid with res_ch=2, res_dq=15'h1234, res_err=0.
REQ-032 Fairness: req=4'b1111 held, datapath latency 2 -> grants in order ch0, ch1, ch2, ch3, ch0; gnt one-hot always.
REQ-033 Wrap: rr_ptr=3 after ch2 served, req=4'b0101 -> ch0 granted next (3 skipped, wraps to 0).
REQ-034 Reset mid-WAIT: assert reset=0 two cycles after dq_start -> all outputs reset values immediately, no res_valid after release; later dq_done ignored in IDLE.
REQ-035 Watchdog (IAQ_SCHED_WDOG_EN, WDOG_LIM=5): dq_done never returned -> res_valid with res_err=1, res_dq=0 exactly 5 WAIT cycles after entry; without macro, FSM stays in WAIT indefinitely.
REQ-036 Stray dq_done in IDLE or same cycle as dq_start -> no state change, no res_valid.
